// File: rtl/regfile_writeback_queue.sv
// Writeback queue between result producers and the register file, with busy/forward lookup for decode.
// Define WB_BYPASS_EN to build the newest-value forwarding mux on fwdData1/fwdData2.
module regfile_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [4:0]               inRegister,
  input  logic [31:0]              inData,
  output logic [4:0]               writeRegister,
  output logic [31:0]              writeData,
  output logic                     RegWrite,
  input  logic [4:0]               queryRegister1,
  input  logic [4:0]               queryRegister2,
  output logic                     busy1,
  output logic                     busy2,
  output logic [31:0]              fwdData1,
  output logic [31:0]              fwdData2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    mem_reg  [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          enq;
  logic          drain_en;

  // Handshake: a result transfers on a rising edge where inValid && inReady;
  // inReady is a function of occupancy only, never of inValid.
  assign inReady  = (count < CW'(DEPTH));
  assign push     = inValid && inReady;
  // Writes to x0 complete the handshake but are architecturally dead, so never queue them.
  assign enq      = push && (inRegister != 5'd0);
  assign drain_en = (count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      RegWrite      <= 1'b0;
      writeRegister <= 5'd0;
      writeData     <= 32'd0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (drain_en) begin
        rd_ptr        <= rd_ptr + 1'b1;
        writeRegister <= mem_reg[rd_ptr];
        writeData     <= mem_data[rd_ptr];
      end
      RegWrite <= drain_en;
      count    <= count + CW'(enq) - CW'(drain_en);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_reg[wr_ptr]  <= inRegister;
      mem_data[wr_ptr] <= inData;
    end
  end

  logic [1:0][4:0]  qry;
  logic [1:0]       busy_v;
  assign qry = {queryRegister2, queryRegister1};

`ifdef WB_BYPASS_EN
  logic [1:0][31:0] fwd_v;
`endif

  // Scan oldest to newest so the last match wins; the output register is
  // older than every queued entry and is checked first.
  always_comb begin
    busy_v = '0;
`ifdef WB_BYPASS_EN
    fwd_v  = '0;
`endif
    for (int p = 0; p < 2; p++) begin
      if (qry[p] != 5'd0) begin
        if (RegWrite && (writeRegister == qry[p])) begin
          busy_v[p] = 1'b1;
`ifdef WB_BYPASS_EN
          fwd_v[p]  = writeData;
`endif
        end
        for (int k = 0; k < DEPTH; k++) begin
          if ((CW'(k) < count) && (mem_reg[rd_ptr + AW'(k)] == qry[p])) begin
            busy_v[p] = 1'b1;
`ifdef WB_BYPASS_EN
            fwd_v[p]  = mem_data[rd_ptr + AW'(k)];
`endif
          end
        end
      end
    end
  end

  assign busy1 = busy_v[0];
  assign busy2 = busy_v[1];

`ifdef WB_BYPASS_EN
  assign fwdData1 = fwd_v[0];
  assign fwdData2 = fwd_v[1];
`else
  assign fwdData1 = 32'd0;
  assign fwdData2 = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: expected writes go into exp_q, a negedge monitor pops and compares.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

`ifdef WB_BYPASS_EN
  localparam logic [31:0] EXP_FWD7 = 32'h22;
`else
  localparam logic [31:0] EXP_FWD7 = 32'h0;
`endif

  logic          clk;
  logic          rst_n;
  logic          inValid;
  logic          inReady;
  logic [4:0]    inRegister;
  logic [31:0]   inData;
  logic [4:0]    writeRegister;
  logic [31:0]   writeData;
  logic          RegWrite;
  logic [4:0]    queryRegister1;
  logic [4:0]    queryRegister2;
  logic          busy1;
  logic          busy2;
  logic [31:0]   fwdData1;
  logic [31:0]   fwdData2;
  logic [CW-1:0] count;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [36:0] exp_q[$];
  logic        wrap_mon     = 1'b0;
  int          max_cnt      = 0;

  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inValid        (inValid),
    .inReady        (inReady),
    .inRegister     (inRegister),
    .inData         (inData),
    .writeRegister  (writeRegister),
    .writeData      (writeData),
    .RegWrite       (RegWrite),
    .queryRegister1 (queryRegister1),
    .queryRegister2 (queryRegister2),
    .busy1          (busy1),
    .busy2          (busy2),
    .fwdData1       (fwdData1),
    .fwdData2       (fwdData2),
    .count          (count)
  );

  // Clock and reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks: each starts on a negedge so one rising edge separates calls
  task automatic push(input logic [4:0] r, input logic [31:0] d);
    @(negedge clk);
    inValid    = 1'b1;
    inRegister = r;
    inData     = d;
    if (r != 5'd0) exp_q.push_back({r, d});
  endtask

  task automatic idle();
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (wrap_mon && (int'(count) > max_cnt)) max_cnt = int'(count);
      if (RegWrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_write: got reg %0d data 0x%0h, expected no write",
                   writeRegister, writeData);
        end else begin
          e = exp_q.pop_front();
          chk("wb_reg", 32'(writeRegister), 32'(e[36:32]));
          chk("wb_data", writeData, e[31:0]);
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    inValid        = 1'b1;
    inRegister     = 5'd3;
    inData         = 32'hCAFE;
    queryRegister1 = 5'd0;
    queryRegister2 = 5'd0;

    // Reset with a push presented: must be ignored
    cycles(3);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_wreg", 32'(writeRegister), 32'd0);
    chk("rst_wdata", writeData, 32'd0);
    chk("rst_inready", 32'(inReady), 32'd1);
    inValid = 1'b0;
    rst_n   = 1'b1;
    cycles(2);
    chk("post_rst_count", 32'(count), 32'd0);

    // Single push and latency
    push(5'd5, 32'hDEADBEEF);
    idle();
    queryRegister1 = 5'd5;
    #1;
    chk("single_count", 32'(count), 32'd1);
    chk("single_rw_early", 32'(RegWrite), 32'd0);
    chk("single_busy_queue", 32'(busy1), 32'd1);
    cycles(1);
    #1;
    chk("single_rw", 32'(RegWrite), 32'd1);
    chk("single_wreg", 32'(writeRegister), 32'd5);
    chk("single_wdata", writeData, 32'hDEADBEEF);
    chk("single_busy_out", 32'(busy1), 32'd1);
    chk("single_count_drained", 32'(count), 32'd0);
    cycles(1);
    #1;
    chk("single_rw_off", 32'(RegWrite), 32'd0);
    chk("single_busy_off", 32'(busy1), 32'd0);
    chk("single_wreg_hold", 32'(writeRegister), 32'd5);
    chk("single_wdata_hold", writeData, 32'hDEADBEEF);

    // x0 drop
    push(5'd0, 32'h1234);
    idle();
    queryRegister1 = 5'd0;
    #1;
    chk("x0_count", 32'(count), 32'd0);
    chk("x0_busy", 32'(busy1), 32'd0);
    cycles(3);
    chk("x0_rw", 32'(RegWrite), 32'd0);

    // Two writes to r7: queue entry beats the output register
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    idle();
    queryRegister1 = 5'd7;
    queryRegister2 = 5'd8;
    #1;
    chk("byp_busy1", 32'(busy1), 32'd1);
    chk("byp_fwd1", fwdData1, EXP_FWD7);
    chk("byp_busy2", 32'(busy2), 32'd0);
    chk("byp_fwd2", fwdData2, 32'd0);
    cycles(4);

    // Fill with the drain held off
    @(negedge clk);
    force dut.drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'hA0 + 32'(i));
    idle();
    #1;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_inready", 32'(inReady), 32'd0);
    chk("fill_rw", 32'(RegWrite), 32'd0);
    @(negedge clk);
    inValid    = 1'b1;
    inRegister = 5'd9;
    inData     = 32'h99;
    #1;
    chk("fill_inready_valid", 32'(inReady), 32'd0);
    @(negedge clk);
    inValid        = 1'b0;
    queryRegister1 = 5'd4;
    queryRegister2 = 5'd9;
    #1;
    chk("fill_count_5th", 32'(count), 32'd4);
    chk("fill_busy_r4", 32'(busy1), 32'd1);
    chk("fill_busy_r9", 32'(busy2), 32'd0);
    release dut.drain_en;
    cycles(6);
    chk("fill_drained", 32'(count), 32'd0);

    // Reset while three are queued and a write is pending
    @(negedge clk);
    force dut.drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push(5'(20 + i), 32'hB000 + 32'(i));
    idle();
    release dut.drain_en;
    @(negedge clk);
    chk("midrst_count_pre", 32'(count), 32'd3);
    chk("midrst_rw_pre", 32'(RegWrite), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_rw", 32'(RegWrite), 32'd0);
    chk("midrst_wreg", 32'(writeRegister), 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    cycles(5);
    chk("midrst_count_after", 32'(count), 32'd0);

    // Continuous stream wrapping the pointers
    wrap_mon = 1'b1;
    max_cnt  = 0;
    for (int i = 0; i < 10; i++) push(5'(10 + i), 32'h1000_0000 + 32'(i) * 32'h111);
    idle();
    cycles(5);
    wrap_mon = 1'b0;
    chk("wrap_count_le2", 32'(max_cnt <= 2), 32'd1);
    chk("wrap_count_end", 32'(count), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
REGFILE_WRITEBACK_QUEUE -- requirements
Module: regfile_writeback_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queue entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock shared with the register file.
REQ-004 Port: rst_n  input  1  synchronous active-low reset.
REQ-005 Port: inValid  input  1  producer offers a result.
REQ-006 Port: inReady  output  1  queue can accept a result.
REQ-007 Port: inRegister  input  5  destination register index.
REQ-008 Port: inData  input  32  result value.
REQ-009 Port: writeRegister  output  5  register-file write index.
REQ-010 Port: writeData  output  32  register-file write data.
REQ-011 Port: RegWrite  output  1  register-file write enable.
REQ-012 Port: queryRegister1, queryRegister2  input  5 each  decode-stage source indices.
REQ-013 Port: busy1, busy2  output  1 each  query index has a pending write.
REQ-014 Port: fwdData1, fwdData2  output  32 each  newest pending value for the query index.
REQ-015 Port: count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-016 Accept: a push SHALL occur on a rising edge with inValid=1 and inReady=1.
REQ-017 inReady SHALL equal (count < DEPTH) and SHALL NOT depend on inValid.
REQ-018 A handshake with inRegister=0 SHALL complete but SHALL NOT enqueue, and count SHALL be unchanged.
REQ-019 Queue order SHALL be FIFO, with circular read and write pointers that wrap from DEPTH-1 to 0.
REQ-020 Drain: on each edge with count>0, the head entry SHALL move into the output registers, and RegWrite SHALL be 1 for the following cycle.
REQ-021 On an edge with count=0, RegWrite SHALL become 0, and writeRegister/writeData SHALL hold their last values.
REQ-022 Latency: a push at edge N SHALL give RegWrite=1 in the cycle after edge N+1, with the register-file write at edge N+2; there is no fall-through path.
REQ-023 A simultaneous push and pop SHALL leave count unchanged; at count=DEPTH, no push is accepted even while popping.
REQ-024 busyX SHALL be 1 when queryRegisterX≠0 and it matches any valid queue entry or the output register while RegWrite=1.
REQ-025 busyX SHALL be 0 for queryRegisterX=0 in all cases.
REQ-026 busy/fwd outputs SHALL be combinational from current state and SHALL NOT reflect an entry being pushed in the same cycle.

Reset
REQ-027 On an edge with rst_n=0, the pointers, count, RegWrite, writeRegister and writeData SHALL all be set to 0.
REQ-028 Reset SHALL discard all queued entries, including a pending output write, so no RegWrite pulse follows reset.
REQ-029 Any push presented during reset SHALL be ignored, and inReady SHALL be 1 on the first cycle after reset.

Configuration
REQ-030 Macro WB_BYPASS_EN: when defined, fwdDataX SHALL be the data of the newest matching entry, with queue entries taking priority over the output register; when no entry matches, fwdDataX SHALL be 0.
REQ-031 When WB_BYPASS_EN is undefined, fwdData1/fwdData2 SHALL be driven to constant 0 and no compare-select logic SHALL be built; busy outputs are unaffected.

Verification
REQ-032 Single push: push reg 5 data 0xDEADBEEF at edge 0 -> RegWrite=1, writeRegister=5, writeData=0xDEADBEEF after edge 1; RegWrite=0 after edge 2.
REQ-033 Fill: with the drain stalled by an external force, push 4 entries -> count=4, inReady=0; a 5th inValid is not accepted; release the drain -> the 4 entries drain in order, one per cycle.
REQ-034 $0 drop: push reg 0 data 0x1234 -> count stays 0, RegWrite never asserts, busy1=0 for query 0.
REQ-035 Bypass (WB_BYPASS_EN): push reg 7=0x11, then reg 7=0x22, and query 7 -> busy1=1 and fwdData1=0x22; query 8 -> busy2=0 and fwdData2=0.
REQ-036 Reset mid-operation: 3 entries queued and RegWrite=1, assert rst_n=0 for one edge -> count=0, RegWrite=0, and no further writes.
REQ-037 Wrap: push and drain 10 entries continuously at DEPTH=4 -> all writes occur in order with correct data and count never exceeds 2.
